scan_chain_loader: RTL and testbench

- Upstream driver for the 4-bit sensor-control scan chain. It accepts a parallel configuration word over a valid/ready handshake and serialises it onto SC_DIN.
- Generates the SC_CLK waveform the chain expects, then pulses SC_LATCH so the chain's parallel outputs update atomically.
- Sits between the sensor control/CSR logic and the scan-chain block in each sensor macro.

---
 rtl/scan_chain_pkg.sv | 16 +
 rtl/sc_half_period_timer.sv | 29 ++
 rtl/scan_chain_loader.sv | 97 +++++++++
 tb/tb_scan_chain_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_chain_pkg.sv
// Shared types and default geometry for the sensor-control scan chain
// and its upstream loader.
package scan_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    TAIL,
    LATCH
  } sc_state_e;

  localparam int SC_WIDTH = 4;
  localparam int SC_DIV   = 2;

endpackage

// File: rtl/sc_half_period_timer.sv
// Counts DIV enabled cycles and flags the last one; wraps to zero on
// expiry so every scan-clock phase lasts exactly DIV cycles.
module sc_half_period_timer #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] count;

  assign expire = enable & (count == CW'(DIV - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (restart || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// Serialises a parallel configuration word onto the scan chain, MSB first,
// generating SC_CLK and finishing with a single SC_LATCH strobe.
module scan_chain_loader
  import scan_chain_pkg::*;
#(
  parameter int WIDTH = SC_WIDTH,
  parameter int DIV   = SC_DIV
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] CFG_DATA,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  output logic             SC_DIN,
  output logic             SC_CLK,
  output logic             SC_LATCH,
  output logic             BUSY,
  output logic             DONE
);

  localparam int BW = $clog2(WIDTH + 1);

  sc_state_e        state;
  sc_state_e        state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [BW-1:0]    bit_cnt;
  logic             accept;
  logic             expire;
  logic             last_bit;

  assign CFG_READY  = (state == IDLE);
  assign BUSY       = ~CFG_READY;
  assign accept     = CFG_READY & CFG_VALID;
  assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
  assign shift_next = shift_reg << 1;

  sc_half_period_timer #(
    .DIV(DIV)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .restart(accept),
    .enable (BUSY),
    .expire (expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (CFG_VALID) state_next = LOW;
      LOW:     if (expire) state_next = HIGH;
      HIGH:    if (expire) state_next = last_bit ? TAIL : LOW;
      TAIL:    if (expire) state_next = LATCH;
      LATCH:   if (expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Scan outputs are registered from the next state so they never glitch;
  // SC_DIN only moves on the HIGH->LOW transition, i.e. the SC_CLK fall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      SC_DIN    <= 1'b0;
      SC_CLK    <= 1'b0;
      SC_LATCH  <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      SC_CLK   <= (state_next == HIGH);
      SC_LATCH <= (state_next == LATCH);
      DONE     <= 1'b0;
      if (accept) begin
        shift_reg <= CFG_DATA;
        bit_cnt   <= '0;
        SC_DIN    <= CFG_DATA[WIDTH-1];
      end else if (state == HIGH && expire && !last_bit) begin
        shift_reg <= shift_next;
        bit_cnt   <= bit_cnt + BW'(1);
        SC_DIN    <= shift_next[WIDTH-1];
      end else if (state == LATCH && expire) begin
        SC_DIN <= 1'b0;
        DONE   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// Self-checking bench: drives two loader instances (4-bit/DIV 2 and
// 8-bit/DIV 1) and compares against a behavioural scan-chain model.
module tb_scan_chain_loader;
  import scan_chain_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       sel;
  int         checks = 0;
  int         errors = 0;
  int         gcyc = 0;

  logic a_ready, a_din, a_sc_clk, a_latch, a_busy, a_done;
  logic b_ready, b_din, b_sc_clk, b_latch, b_busy, b_done;
  logic m_ready, m_din, m_sc_clk, m_latch, m_busy, m_done;

  scan_chain_loader #(.WIDTH(SC_WIDTH), .DIV(SC_DIV)) dut_a (
    .CLK(clk), .RST(rst), .CFG_DATA(cfg_data[3:0]), .CFG_VALID(cfg_valid & ~sel),
    .CFG_READY(a_ready), .SC_DIN(a_din), .SC_CLK(a_sc_clk), .SC_LATCH(a_latch),
    .BUSY(a_busy), .DONE(a_done)
  );

  scan_chain_loader #(.WIDTH(8), .DIV(1)) dut_b (
    .CLK(clk), .RST(rst), .CFG_DATA(cfg_data), .CFG_VALID(cfg_valid & sel),
    .CFG_READY(b_ready), .SC_DIN(b_din), .SC_CLK(b_sc_clk), .SC_LATCH(b_latch),
    .BUSY(b_busy), .DONE(b_done)
  );

  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_din    = sel ? b_din    : a_din;
  assign m_sc_clk = sel ? b_sc_clk : a_sc_clk;
  assign m_latch  = sel ? b_latch  : a_latch;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Invariants on both instances, sampled away from the active edge.
  logic [1:0] v_clk, v_latch, v_din, v_done;
  logic [1:0] p_clk = '0, p_din = '0, p_done = '0;
  assign v_clk   = {b_sc_clk, a_sc_clk};
  assign v_latch = {b_latch, a_latch};
  assign v_din   = {b_din, a_din};
  assign v_done  = {b_done, a_done};

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (v_clk[i] && v_latch[i]) begin
          errors++;
          $display("[TB] FAIL inv_clk_latch inst%0d: SC_CLK=1 SC_LATCH=1, required not both high", i);
        end
        if (p_clk[i] && v_clk[i] && (v_din[i] !== p_din[i])) begin
          errors++;
          $display("[TB] FAIL inv_din_stable inst%0d: SC_DIN=%b was %b while SC_CLK high", i, v_din[i], p_din[i]);
        end
        if (p_done[i] && v_done[i]) begin
          errors++;
          $display("[TB] FAIL inv_done_pulse inst%0d: DONE high 2 cycles, required 1", i);
        end
      end
      p_clk  = v_clk;
      p_din  = v_din;
      p_done = v_done;
    end else begin
      p_clk  = '0;
      p_din  = '0;
      p_done = '0;
    end
  end

  // Behavioural chain model: shifts on SC_CLK rise, copies to S on latch.
  logic [7:0] chain_sr = '0;
  logic [7:0] s_out = '0;
  logic [7:0] cap_stream;
  int cap_rises, cap_high, cap_latch, cap_done_cyc, cap_done_at;
  int cap_first_rise, cap_last_rise;
  bit cap_timeout;
  logic cap_ready_done;

  task automatic capture(input logic [7:0] word, input bit skip_drive, input bit hold_valid,
                         input logic [7:0] next_word, input logic [7:0] inj_word,
                         input int inj_start, input int inj_end);
    int cyc;
    logic prev_clk;
    logic [7:0] mask;
    mask = sel ? 8'hFF : 8'h0F;
    cap_stream = '0; cap_rises = 0; cap_high = 0; cap_latch = 0;
    cap_done_cyc = -1; cap_done_at = -1; cap_timeout = 0;
    cap_first_rise = -1; cap_last_rise = -1; cap_ready_done = 1'b0;
    if (!skip_drive) begin
      cfg_data = word;
      cfg_valid = 1'b1;
    end
    @(negedge clk);
    if (!hold_valid) cfg_valid = 1'b0;
    cyc = 0;
    prev_clk = m_sc_clk;
    while (cap_done_cyc < 0 && cyc < 200) begin
      if (inj_start > 0 && cyc == inj_start) begin
        cfg_data = inj_word;
        cfg_valid = 1'b1;
      end
      if (inj_end > 0 && cyc == inj_end) cfg_valid = 1'b0;
      @(negedge clk);
      cyc++;
      if (m_sc_clk && !prev_clk) begin
        chain_sr = {chain_sr[6:0], m_din};
        cap_stream = {cap_stream[6:0], m_din};
        cap_rises++;
        if (cap_first_rise < 0) cap_first_rise = cyc;
        cap_last_rise = cyc;
      end
      if (m_sc_clk) cap_high++;
      if (m_latch) begin
        cap_latch++;
        s_out = chain_sr & mask;
      end
      if (m_done) begin
        cap_done_cyc = cyc;
        cap_done_at = gcyc;
        cap_ready_done = m_ready;
        if (hold_valid) cfg_data = next_word;
      end
      prev_clk = m_sc_clk;
    end
    if (cap_done_cyc < 0) cap_timeout = 1'b1;
  endtask

  task automatic test_reset;
    int edges;
    sel = 1'b0; rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, a_din, a_sc_clk, a_latch, a_busy, a_done} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_state_a: {rdy,din,clk,lat,busy,done}=%b, required 100000",
               {a_ready, a_din, a_sc_clk, a_latch, a_busy, a_done});
    end
    checks++;
    if ({b_ready, b_din, b_sc_clk, b_latch, b_busy, b_done} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_state_b: {rdy,din,clk,lat,busy,done}=%b, required 100000",
               {b_ready, b_din, b_sc_clk, b_latch, b_busy, b_done});
    end
    rst = 1'b0;
    @(negedge clk);
    cfg_data = 8'h0B; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_busy, m_din, m_ready} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL midlow_state: {busy,din,rdy}=%b, required 110", {m_busy, m_din, m_ready});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_ready, m_din, m_sc_clk, m_latch, m_busy, m_done} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL async_abort: {rdy,din,clk,lat,busy,done}=%b, required 100000",
               {m_ready, m_din, m_sc_clk, m_latch, m_busy, m_done});
    end
    cfg_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({m_ready, m_busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL valid_in_reset: {rdy,busy}=%b, required 10", {m_ready, m_busy});
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_sc_clk || m_busy) edges++;
    end
    checks++;
    if (edges !== 0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: %0d active cycles, required 0", edges);
    end
  endtask

  task automatic test_basic_load;
    sel = 1'b0;
    capture(8'h0B, 1'b0, 1'b0, 8'h00, 8'h00, 0, 0);
    checks++;
    if (cap_timeout) begin errors++; $display("[TB] FAIL basic_timeout: no DONE in 200 cycles, required DONE"); end
    checks++;
    if (cap_stream[3:0] !== 4'b1011) begin errors++; $display("[TB] FAIL basic_stream: %b, required 1011", cap_stream[3:0]); end
    checks++;
    if (cap_rises !== 4) begin errors++; $display("[TB] FAIL basic_rises: %0d, required 4", cap_rises); end
    checks++;
    if (cap_latch !== 2) begin errors++; $display("[TB] FAIL basic_latch_len: %0d, required 2", cap_latch); end
    checks++;
    if (cap_done_cyc !== 20) begin errors++; $display("[TB] FAIL basic_done_cycle: %0d, required 20", cap_done_cyc); end
    checks++;
    if (cap_high !== 8) begin errors++; $display("[TB] FAIL basic_clk_high: %0d, required 8", cap_high); end
    checks++;
    if (s_out[3:0] !== 4'b1011) begin errors++; $display("[TB] FAIL basic_chain_s: S4..S1=%b, required 1011", s_out[3:0]); end
  endtask

  task automatic test_busy_reject;
    sel = 1'b0;
    s_out = '0;
    capture(8'h0B, 1'b0, 1'b0, 8'h00, 8'h06, 5, 8);
    checks++;
    if (s_out[3:0] !== 4'b1011 || cap_done_cyc !== 20) begin
      errors++;
      $display("[TB] FAIL busy_reject: S=%b done=%0d, required S=1011 done=20", s_out[3:0], cap_done_cyc);
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({m_ready, m_busy} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL busy_reject_idle: {rdy,busy}=%b, required 10", {m_ready, m_busy});
    end
  endtask

  task automatic test_back_to_back;
    int first_done;
    sel = 1'b0;
    capture(8'h01, 1'b0, 1'b1, 8'h08, 8'h00, 0, 0);
    first_done = cap_done_at;
    checks++;
    if (s_out[3:0] !== 4'b0001 || cap_ready_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_first: S=%b rdy_at_done=%b, required S=0001 rdy=1", s_out[3:0], cap_ready_done);
    end
    capture(8'h08, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0);
    checks++;
    if (s_out[3:0] !== 4'b1000) begin errors++; $display("[TB] FAIL b2b_second_s: S=%b, required 1000", s_out[3:0]); end
    checks++;
    if (cap_done_at - first_done !== 21) begin
      errors++;
      $display("[TB] FAIL b2b_done_gap: %0d, required 21", cap_done_at - first_done);
    end
  endtask

  task automatic test_div1_width8;
    sel = 1'b1;
    capture(8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 0, 0);
    checks++;
    if (cap_stream !== 8'hA5) begin errors++; $display("[TB] FAIL div1_stream: %b, required 10100101", cap_stream); end
    checks++;
    if (cap_done_cyc !== 18) begin errors++; $display("[TB] FAIL div1_done_cycle: %0d, required 18", cap_done_cyc); end
    checks++;
    if (cap_rises !== 8 || cap_last_rise - cap_first_rise !== 14 || cap_high !== 8) begin
      errors++;
      $display("[TB] FAIL div1_clk_period: rises=%0d span=%0d high=%0d, required 8/14/8",
               cap_rises, cap_last_rise - cap_first_rise, cap_high);
    end
    checks++;
    if (s_out !== 8'hA5 || cap_latch !== 1) begin
      errors++;
      $display("[TB] FAIL div1_chain: S=%h latch=%0d, required A5/1", s_out, cap_latch);
    end
  endtask

  task automatic test_random;
    int w, d;
    logic [7:0] word, mask;
    for (int n = 0; n < 8; n++) begin
      sel = 1'($urandom_range(0, 1));
      word = 8'($urandom);
      w = sel ? 8 : 4;
      d = sel ? 1 : 2;
      mask = sel ? 8'hFF : 8'h0F;
      capture(word, 1'b0, 1'b0, 8'h00, 8'h00, 0, 0);
      checks++;
      if ((cap_stream & mask) !== (word & mask) || cap_rises !== w) begin
        errors++;
        $display("[TB] FAIL rand_stream[%0d]: %h rises=%0d, required %h rises=%0d",
                 n, cap_stream & mask, cap_rises, word & mask, w);
      end
      checks++;
      if (cap_done_cyc !== (2 * w + 2) * d || cap_latch !== d || cap_high !== w * d) begin
        errors++;
        $display("[TB] FAIL rand_timing[%0d]: done=%0d latch=%0d high=%0d, required %0d/%0d/%0d",
                 n, cap_done_cyc, cap_latch, cap_high, (2 * w + 2) * d, d, w * d);
      end
      checks++;
      if (s_out !== (word & mask)) begin
        errors++;
        $display("[TB] FAIL rand_chain[%0d]: S=%h, required %h", n, s_out, word & mask);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_basic_load;
    test_busy_reject;
    test_back_to_back;
    test_div1_width8;
    test_random;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at 500000, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
